// File: rtl/siso_shift_ctrl_if.sv
// siso_shift_ctrl_if -- frame request / serial output bundle for siso_shift_ctrl.
//
// Parameter N : frame width in bits (2..32).
// master modport (frame source side):
//   start_in, data_in[N-1:0], abort_in                        -> controller
//   ready_out, ser_out, shift_en_out, busy_out, done_out,
//   bit_cnt_out[$clog2(N):0]                                  <- controller
// slave modport (controller side): the same signals with opposite directions.
interface siso_shift_ctrl_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N) + 1;

  logic          start_in;
  logic [N-1:0]  data_in;
  logic          abort_in;
  logic          ready_out;
  logic          ser_out;
  logic          shift_en_out;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] bit_cnt_out;

  modport master (
    output start_in, data_in, abort_in,
    input  ready_out, ser_out, shift_en_out, busy_out, done_out, bit_cnt_out
  );

  modport slave (
    input  start_in, data_in, abort_in,
    output ready_out, ser_out, shift_en_out, busy_out, done_out, bit_cnt_out
  );
endinterface

// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl -- converts a parallel N-bit word into an MSB-first serial
// frame for a downstream SISO shift register.
//
// Ports:
//   clk          : single clock, all state changes on the rising edge
//   reset_al_in  : asynchronous active-low reset, forces IDLE
//   bus (slave)  : start_in / data_in / abort_in request side,
//                  ready_out / ser_out / shift_en_out / busy_out / done_out /
//                  bit_cnt_out status and serial side
//
// Frame: accept (start_in & ready_out), N data bits MSB-first with
// shift_en_out high, optional even-parity bit, one-cycle done_out, back to IDLE.
// abort_in in SHIFT/PARITY drops the frame without done_out; abort_in beats
// start_in in IDLE and is ignored in DONE.
//
// Build option: define SISO_SHIFT_CTRL_PARITY_EN to append the even-parity bit
// (PARITY state, bit_cnt_out = N). Undefined: SHIFT goes straight to DONE.
//
// All outputs decode from state and registers only; no input reaches an
// output combinationally.
module siso_shift_ctrl #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset_al_in,
  siso_shift_ctrl_if.slave bus
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    PARITY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  hold;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_bit;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  // Parity is taken from the word at acceptance because the hold register
  // is consumed by shifting before the parity bit goes out.
  logic          par;
`endif

  always_comb begin
    accept   = (state == IDLE) && bus.start_in && !bus.abort_in;
    last_bit = (cnt == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bus.abort_in) begin
          state_nxt = IDLE;
        end else if (last_bit) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
      PARITY: begin
        state_nxt = bus.abort_in ? IDLE : DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Hold register and bit counter
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      hold <= '0;
      cnt  <= '0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
      par  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            hold <= bus.data_in;
            cnt  <= '0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            par  <= ^bus.data_in;
`endif
          end
        end
        SHIFT: begin
          if (bus.abort_in) begin
            cnt <= '0;
          end else begin
            hold <= {hold[N-2:0], 1'b0};
            if (last_bit) begin
              // Counter reaches N only when a parity bit follows; otherwise
              // it parks at zero so it never exceeds N-1.
`ifdef SISO_SHIFT_CTRL_PARITY_EN
              cnt <= cnt + 1'b1;
`else
              cnt <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
        PARITY: begin
          cnt <= '0;
        end
`endif
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.ready_out    = (state == IDLE);
    bus.busy_out     = (state != IDLE);
    bus.done_out     = (state == DONE);
    bus.shift_en_out = 1'b0;
    bus.ser_out      = 1'b0;
    bus.bit_cnt_out  = cnt;
    unique case (state)
      SHIFT: begin
        bus.shift_en_out = 1'b1;
        bus.ser_out      = hold[N-1];
      end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
      PARITY: begin
        bus.shift_en_out = 1'b1;
        bus.ser_out      = par;
      end
`endif
      default: begin
        bus.shift_en_out = 1'b0;
        bus.ser_out      = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/siso_shift_ctrl.md
SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

Interface
REQ-001 Parameter N, default 4, frame width in bits; legal range 2..32.
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port reset_al_in, input, 1, asynchronous active-low reset.
REQ-004 Port start_in, input, 1, frame request; accepted only when start_in and ready_out are both high at a rising edge.
REQ-005 Port data_in, input, N, parallel frame word, sampled on acceptance.
REQ-006 Port abort_in, input, 1, synchronous frame cancel.
REQ-007 Port ready_out, output, 1, high only in IDLE.
REQ-008 Port ser_out, output, 1, serial bit driving the downstream SISO register d_in.
REQ-009 Port shift_en_out, output, 1, high in every cycle where ser_out carries a valid frame bit.
REQ-010 Port busy_out, output, 1, high in SHIFT, PARITY and DONE.
REQ-011 Port done_out, output, 1, one-cycle pulse at frame completion.
REQ-012 Port bit_cnt_out, output, clog2(N)+1, index of the bit currently on ser_out.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT, PARITY and DONE.
REQ-014 IDLE SHALL drive ready_out=1, shift_en_out=0 and ser_out=0.
REQ-015 Acceptance at edge k SHALL capture data_in into an internal hold register, clear the counter and enter SHIFT.
REQ-016 ser_out SHALL carry the MSB (data_in[N-1]) in cycle k+1, then one bit per cycle MSB-first, with the last bit in cycle k+N.
REQ-017 In SHIFT, each edge SHALL shift the hold register left by one and increment bit_cnt_out, which runs 0..N-1.
REQ-018 When bit_cnt_out=N-1, the next edge SHALL enter PARITY if PARITY_EN is defined, otherwise DONE.
REQ-019 PARITY SHALL last one cycle, with ser_out = XOR of the captured word (even parity), shift_en_out=1 and bit_cnt_out=N.
REQ-020 DONE SHALL last one cycle, with done_out=1, shift_en_out=0 and ready_out=0, then return to IDLE.
REQ-021 Frame period: without PARITY_EN, N+1 cycles from acceptance to done, N+2 cycles back-to-back; with PARITY_EN, one cycle more for each.
REQ-022 start_in while ready_out=0 SHALL be ignored and SHALL NOT be queued.
REQ-023 abort_in=1 in SHIFT or PARITY SHALL return the FSM to IDLE at the next edge, with no done_out pulse and shift_en_out low from that edge.
REQ-024 abort_in and start_in together in IDLE: abort SHALL win and the start SHALL be ignored.
REQ-025 abort_in in DONE SHALL have no effect; done_out still pulses.
REQ-026 data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-027 All outputs SHALL be registered or decoded from state only, with no combinational path from any input.

Reset
REQ-028 reset_al_in=0 SHALL immediately force IDLE and clear the hold register and counter.
REQ-029 During reset, outputs SHALL be: ready_out=1, ser_out=0, shift_en_out=0, busy_out=0, done_out=0, bit_cnt_out=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no done_out pulse.
REQ-031 The first acceptance SHALL be possible at the first rising edge after reset_al_in deasserts.

Configuration
REQ-032 Macro SISO_SHIFT_CTRL_PARITY_EN defined SHALL include the PARITY state and append the even-parity bit after the data bits.
REQ-033 Macro SISO_SHIFT_CTRL_PARITY_EN undefined SHALL remove the PARITY state; SHIFT goes directly to DONE and bit_cnt_out never exceeds N-1.

Verification (N=4)
REQ-034 Scenario: reset low 50 ns, then start_in=1 with data_in=4'b1011 -> ser_out 1,0,1,1 in the next 4 cycles, shift_en_out high for 4 cycles, done_out pulse in cycle 5, ready_out high in cycle 6.
REQ-035 Scenario: SISO_SHIFT_CTRL_PARITY_EN defined, data_in=4'b1011 -> 5th bit ser_out=1 with bit_cnt_out=4, done_out in cycle 6.
REQ-036 Scenario: start_in held high with data_in 4'hA then 4'h5 -> two frames, 6 cycles apart; the start pulses while busy are not accepted.
REQ-037 Scenario: abort_in pulsed with bit_cnt_out=2 -> IDLE next edge, no done_out, shift_en_out=0, ready_out=1.
REQ-038 Scenario: reset_al_in dropped mid-frame, between clock edges -> all outputs at reset values immediately; a new frame is accepted after release.
REQ-039 Scenario: abort_in and start_in high together in IDLE -> no frame starts; ready_out stays 1.
